// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding selects, load-use and Hi/Lo multiply stall detection
// Define FWD_HAZARD_FWD_EN to forward; otherwise any in-flight RAW hazard stalls until it retires.
module fwd_hazard_unit #(
   parameter int REG_AW     = 5,
   parameter int DEPTH      = 3,
   parameter int MUL_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       Reset,
   input  logic                       id_valid,
   input  logic [REG_AW-1:0]          id_rs,
   input  logic [REG_AW-1:0]          id_rt,
   input  logic                       id_uses_rs,
   input  logic                       id_uses_rt,
   input  logic [REG_AW-1:0]          id_rd,
   input  logic                       id_regwrite,
   input  logic                       id_memread,
   input  logic                       id_mult,
   input  logic                       id_hilo_read,
   input  logic                       id_flush,
   output logic                       stall,
   output logic [$clog2(DEPTH+1)-1:0] ex_fwd_a,
   output logic [$clog2(DEPTH+1)-1:0] ex_fwd_b,
   output logic                       mul_busy
);
   localparam int FW = $clog2(DEPTH + 1);
   localparam int CW = 4;

   logic [DEPTH-1:0]  valid_q;
   logic [DEPTH-1:0]  regwrite_q;
   logic [REG_AW-1:0] rd_q [DEPTH];
   // Only the EX entry's load flag matters: older loads have their data by then.
   logic              memread0_q;
   logic [CW-1:0]     mul_cnt_q;
   logic [CW-1:0]     mul_cnt_d;

   logic [FW-1:0]     rs_sel;
   logic [FW-1:0]     rt_sel;
   logic              load_haz;
   logic              data_haz;
   logic              mul_haz;
   logic              issue;

   // Select value k+1 for a hit in entry k; scanning oldest to youngest lets the youngest win.
   always_comb begin
      rs_sel = '0;
      rt_sel = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (id_uses_rs && valid_q[k] && regwrite_q[k] && rd_q[k] == id_rs && id_rs != '0)
            rs_sel = FW'(k + 1);
         if (id_uses_rt && valid_q[k] && regwrite_q[k] && rd_q[k] == id_rt && id_rt != '0)
            rt_sel = FW'(k + 1);
      end
   end

   always_comb begin
      load_haz = memread0_q && (rs_sel == FW'(1) || rt_sel == FW'(1));
`ifdef FWD_HAZARD_FWD_EN
      data_haz = load_haz;
`else
      data_haz = load_haz || rs_sel != '0 || rt_sel != '0;
`endif
      mul_haz  = (id_mult || id_hilo_read) && mul_busy;
      stall    = !Reset && id_valid && !id_flush && (data_haz || mul_haz);
      issue    = id_valid && !stall && !id_flush;
   end

   always_comb begin
      mul_cnt_d = mul_cnt_q;
      if (issue && id_mult)
         mul_cnt_d = CW'(MUL_CYCLES);
      else if (mul_cnt_q != '0)
         mul_cnt_d = mul_cnt_q - CW'(1);
   end

   assign mul_busy = mul_cnt_q != '0;

   always_ff @(posedge clk) begin
      if (Reset) begin
         valid_q    <= '0;
         regwrite_q <= '0;
         memread0_q <= 1'b0;
         mul_cnt_q  <= '0;
         for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
      end else begin
         for (int k = 1; k < DEPTH; k++) begin
            valid_q[k]    <= valid_q[k-1];
            regwrite_q[k] <= regwrite_q[k-1];
            rd_q[k]       <= rd_q[k-1];
         end
         valid_q[0]    <= issue;
         regwrite_q[0] <= issue && id_regwrite;
         memread0_q    <= issue && id_memread;
         rd_q[0]       <= id_rd;
         mul_cnt_q     <= mul_cnt_d;
      end
   end

`ifdef FWD_HAZARD_FWD_EN
   logic [FW-1:0] ex_fwd_a_q;
   logic [FW-1:0] ex_fwd_b_q;

   always_ff @(posedge clk) begin
      if (Reset) begin
         ex_fwd_a_q <= '0;
         ex_fwd_b_q <= '0;
      end else begin
         ex_fwd_a_q <= issue ? rs_sel : '0;
         ex_fwd_b_q <= issue ? rt_sel : '0;
      end
   end

   assign ex_fwd_a = ex_fwd_a_q;
   assign ex_fwd_b = ex_fwd_b_q;
`else
   assign ex_fwd_a = '0;
   assign ex_fwd_b = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed bench for fwd_hazard_unit in either forwarding build
module tb_fwd_hazard_unit;
   localparam int REG_AW     = 5;
   localparam int DEPTH      = 3;
   localparam int MUL_CYCLES = 4;
   localparam int FW         = $clog2(DEPTH + 1);
`ifdef FWD_HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic              clk;
   logic              Reset;
   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic [REG_AW-1:0] id_rd;
   logic              id_regwrite;
   logic              id_memread;
   logic              id_mult;
   logic              id_hilo_read;
   logic              id_flush;
   logic              stall;
   logic [FW-1:0]     ex_fwd_a;
   logic [FW-1:0]     ex_fwd_b;
   logic              mul_busy;

   int n_checks = 0;
   int n_fail   = 0;

   fwd_hazard_unit #(.REG_AW(REG_AW), .DEPTH(DEPTH), .MUL_CYCLES(MUL_CYCLES)) dut (
      .clk(clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_mult(id_mult),
      .id_hilo_read(id_hilo_read), .id_flush(id_flush), .stall(stall),
      .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .mul_busy(mul_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      id_valid = 0; id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0; id_rd = '0;
      id_regwrite = 0; id_memread = 0; id_mult = 0; id_hilo_read = 0; id_flush = 0;
      #1;
   endtask

   task automatic issue(input logic [REG_AW-1:0] rd, input logic rw, input logic mr,
                        input logic [REG_AW-1:0] rs, input logic urs,
                        input logic [REG_AW-1:0] rt, input logic urt,
                        input logic mult, input logic hilo);
      id_valid = 1; id_rd = rd; id_regwrite = rw; id_memread = mr;
      id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
      id_mult = mult; id_hilo_read = hilo; id_flush = 0;
      #1;
   endtask

   task automatic drain;
      idle();
      repeat (MUL_CYCLES + DEPTH + 1) tick();
   endtask

   task automatic test_reset;
      Reset = 1;
      idle();
      tick(); tick();
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
      n_checks++; if (mul_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mul_busy got %b want 0", mul_busy); end
      n_checks++; if (ex_fwd_a !== '0 || ex_fwd_b !== '0) begin n_fail++; $display("FAIL reset_fwd got %0d/%0d want 0/0", ex_fwd_a, ex_fwd_b); end
      Reset = 0;
      #1;
   endtask

   task automatic test_raw;
      int ns = FWD ? 0 : DEPTH;
      issue(5'd3, 1, 0, 5'd1, 1, 5'd2, 1, 0, 0);
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_producer_stall got %b want 0", stall); end
      tick();
      issue(5'd9, 1, 0, 5'd3, 1, 5'd0, 0, 0, 0);
      for (int i = 0; i < ns; i++) begin
         n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall[%0d] got %b want 1", i, stall); end
         tick();
         n_checks++; if (ex_fwd_a !== '0) begin n_fail++; $display("FAIL raw_bubble_sel[%0d] got %0d want 0", i, ex_fwd_a); end
      end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_release got %b want 0", stall); end
      tick();
      n_checks++; if (ex_fwd_a !== FW'(FWD ? 1 : 0)) begin n_fail++; $display("FAIL raw_fwd_a got %0d want %0d", ex_fwd_a, FWD ? 1 : 0); end
      drain();
   endtask

   task automatic test_load_use;
      int ns = FWD ? 1 : DEPTH;
      issue(5'd4, 1, 1, 5'd0, 0, 5'd0, 0, 0, 0);
      tick();
      issue(5'd10, 1, 0, 5'd1, 1, 5'd4, 1, 0, 0);
      for (int i = 0; i < ns; i++) begin
         n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall[%0d] got %b want 1", i, stall); end
         tick();
         n_checks++; if (ex_fwd_b !== '0) begin n_fail++; $display("FAIL lu_bubble_sel[%0d] got %0d want 0", i, ex_fwd_b); end
      end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_release got %b want 0", stall); end
      tick();
      n_checks++; if (ex_fwd_b !== FW'(FWD ? 2 : 0)) begin n_fail++; $display("FAIL lu_fwd_b got %0d want %0d", ex_fwd_b, FWD ? 2 : 0); end
      drain();
   endtask

   task automatic test_youngest;
      int ns = FWD ? 0 : DEPTH;
      issue(5'd5, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0); tick();
      issue(5'd6, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0); tick();
      issue(5'd5, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0); tick();
      issue(5'd11, 1, 0, 5'd5, 1, 5'd6, 1, 0, 0);
      for (int i = 0; i < ns; i++) begin
         n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL young_stall[%0d] got %b want 1", i, stall); end
         tick();
      end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL young_release got %b want 0", stall); end
      tick();
      n_checks++; if (ex_fwd_a !== FW'(FWD ? 1 : 0)) begin n_fail++; $display("FAIL young_fwd_a got %0d want %0d", ex_fwd_a, FWD ? 1 : 0); end
      n_checks++; if (ex_fwd_b !== FW'(FWD ? 2 : 0)) begin n_fail++; $display("FAIL young_fwd_b got %0d want %0d", ex_fwd_b, FWD ? 2 : 0); end
      drain();
   endtask

   task automatic test_r0;
      issue(5'd0, 1, 1, 5'd0, 0, 5'd0, 0, 0, 0);
      tick();
      issue(5'd12, 1, 0, 5'd0, 1, 5'd0, 1, 0, 0);
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall got %b want 0", stall); end
      tick();
      n_checks++; if (ex_fwd_a !== '0 || ex_fwd_b !== '0) begin n_fail++; $display("FAIL r0_sel got %0d/%0d want 0/0", ex_fwd_a, ex_fwd_b); end
      drain();
   endtask

   task automatic test_mul;
      issue(5'd0, 0, 0, 5'd1, 1, 5'd2, 1, 1, 0);
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mul_issue_stall got %b want 0", stall); end
      tick();
      n_checks++; if (mul_busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy_start got %b want 1", mul_busy); end
      issue(5'd8, 1, 0, 5'd0, 0, 5'd0, 0, 0, 1);
      for (int i = 0; i < MUL_CYCLES; i++) begin
         n_checks++; if (stall !== 1'b1 || mul_busy !== 1'b1) begin n_fail++; $display("FAIL mfhi_stall[%0d] got stall=%b busy=%b want 1/1", i, stall, mul_busy); end
         tick();
      end
      n_checks++; if (stall !== 1'b0 || mul_busy !== 1'b0) begin n_fail++; $display("FAIL mfhi_issue got stall=%b busy=%b want 0/0", stall, mul_busy); end
      drain();
   endtask

   task automatic test_back_to_back;
      issue(5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
      tick();
      for (int i = 0; i < MUL_CYCLES; i++) begin
         n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mul2_stall[%0d] got %b want 1", i, stall); end
         tick();
      end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mul2_release got %b want 0", stall); end
      tick();
      n_checks++; if (mul_busy !== 1'b1) begin n_fail++; $display("FAIL mul2_reload got %b want 1", mul_busy); end
      Reset = 1;
      idle();
      tick();
      n_checks++; if (mul_busy !== 1'b0) begin n_fail++; $display("FAIL mul_reset_busy got %b want 0", mul_busy); end
      Reset = 0;
      issue(5'd8, 1, 0, 5'd0, 0, 5'd0, 0, 0, 1);
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mul_reset_mfhi got %b want 0", stall); end
      drain();
   endtask

   task automatic test_flush;
      int ns = FWD ? 0 : DEPTH - 1;
      issue(5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
      id_flush = 1; #1;
      tick();
      n_checks++; if (mul_busy !== 1'b0) begin n_fail++; $display("FAIL flush_mult_busy got %b want 0", mul_busy); end
      issue(5'd4, 1, 1, 5'd0, 0, 5'd0, 0, 0, 0);
      tick();
      issue(5'd13, 1, 0, 5'd0, 0, 5'd4, 1, 0, 0);
      id_flush = 1; #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_override got %b want 0", stall); end
      tick();
      id_flush = 0; #1;
      for (int i = 0; i < ns; i++) begin
         n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_after_stall[%0d] got %b want 1", i, stall); end
         tick();
      end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_after_release got %b want 0", stall); end
      tick();
      n_checks++; if (ex_fwd_b !== FW'(FWD ? 2 : 0)) begin n_fail++; $display("FAIL flush_after_fwd_b got %0d want %0d", ex_fwd_b, FWD ? 2 : 0); end
      drain();
   endtask

   task automatic test_reset_mid_load;
      issue(5'd4, 1, 1, 5'd0, 0, 5'd0, 0, 0, 0);
      tick();
      issue(5'd14, 1, 0, 5'd0, 0, 5'd4, 1, 0, 0);
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_load_pre got %b want 1", stall); end
      Reset = 1; #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_load_during got %b want 0", stall); end
      tick();
      Reset = 0; #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_load_after got %b want 0", stall); end
      tick();
      n_checks++; if (ex_fwd_b !== '0) begin n_fail++; $display("FAIL rst_load_sel got %0d want 0", ex_fwd_b); end
      drain();
   endtask

   initial begin
      Reset = 1;
      idle();
      test_reset();
      test_raw();
      test_load_use();
      test_youngest();
      test_r0();
      test_mul();
      test_back_to_back();
      test_flush();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
